// File: rtl/spi_slave_framed.sv
// spi_slave_framed
// ----------------
// SPI mode-0 slave front-end for the SPI/RAM subsystem. The block samples one
// bit per clk while ss_n is low. A frame is one rd/wr select bit followed by
// RX_W bits: a 2-bit command and then an ADDR_W-bit payload. The completed
// word appears on rx_data with a one-cycle rx_valid strobe. A read-data frame
// then waits for the memory side through tx_valid/tx_ready and shifts DATA_W
// bits out on miso. Raising ss_n before the frame completes aborts it and
// produces a one-cycle frame_err strobe.
//
// Ports
//   clk        system clock; all logic runs on the rising edge
//   rst        synchronous reset, active-high
//   ss_n       slave select, active-low
//   mosi       serial data from the master
//   tx_data    read data from the memory side (DATA_W bits)
//   tx_valid   tx_data valid; it is only looked at while tx_ready is high
//   miso       serial data to the master (registered; 0 outside SEND)
//   rx_data    last completed frame; the top two bits are the command
//   rx_valid   one-cycle strobe when rx_data updates
//   tx_ready   high while the block waits for read data
//   frame_err  one-cycle strobe when a frame is aborted
//   busy       high whenever the FSM is not idle
module spi_slave_framed #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int LSB_FIRST = 0,
    localparam int RX_W     = ADDR_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              mosi,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              miso,
    output logic [RX_W-1:0]   rx_data,
    output logic              rx_valid,
    output logic              tx_ready,
    output logic              frame_err,
    output logic              busy
);

    localparam int MAX_W = (RX_W > DATA_W) ? RX_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, RX, WAIT_TX, SEND, DONE} state_t;
    typedef enum logic [1:0] {K_WRITE, K_RDADDR, K_RDDATA} kind_t;

    state_t            state, state_next;
    kind_t             kind, kind_sel;
    logic [CNT_W-1:0]  cnt;
    logic [RX_W-1:0]   rx_sh;
    logic [DATA_W-1:0] tx_sh;
    logic              addr_pending;

    logic load_rx, shift_rx, complete_rx, load_tx, shift_tx, finish_tx, abort;

    // The first received bit ends up at the MSB, or at the LSB when
    // LSB_FIRST is set.
    function automatic logic [RX_W-1:0] rx_shift(input logic [RX_W-1:0] sh,
                                                 input logic b);
        if (LSB_FIRST != 0)
            return {b, sh[RX_W-1:1]};
        else
            return {sh[RX_W-2:0], b};
    endfunction

    function automatic logic tx_bit(input logic [DATA_W-1:0] sh);
        if (LSB_FIRST != 0)
            return sh[0];
        else
            return sh[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] sh);
        if (LSB_FIRST != 0)
            return sh >> 1;
        else
            return sh << 1;
    endfunction

    assign busy     = (state != IDLE);
    assign tx_ready = (state == WAIT_TX);

    // A read whose address was already sent fetches data. A read with no
    // pending address is taken as the address phase.
    always_comb begin
        kind_sel = K_WRITE;
        if (mosi)
            kind_sel = addr_pending ? K_RDDATA : K_RDADDR;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load_rx     = 1'b0;
        shift_rx    = 1'b0;
        complete_rx = 1'b0;
        load_tx     = 1'b0;
        shift_tx    = 1'b0;
        finish_tx   = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (!ss_n)
                    state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (ss_n) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    load_rx    = 1'b1;
                    state_next = RX;
                end
            end
            RX: begin
                // The final bit is still captured when ss_n rises with it.
                if (cnt == CNT_W'(1)) begin
                    complete_rx = 1'b1;
                    if (ss_n)
                        state_next = IDLE;
                    else if (kind == K_RDDATA)
                        state_next = WAIT_TX;
                    else
                        state_next = DONE;
                end else if (ss_n) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    shift_rx = 1'b1;
                end
            end
            WAIT_TX: begin
                if (ss_n) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (tx_valid) begin
                    load_tx    = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (ss_n) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    finish_tx  = 1'b1;
                    state_next = DONE;
                end else begin
                    shift_tx = 1'b1;
                end
            end
            DONE: begin
                if (ss_n)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The strobes and miso default to 0 each cycle. miso holds a bit only
    // while the FSM sits in SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso         <= 1'b0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            rx_data      <= '0;
            addr_pending <= 1'b0;
            cnt          <= '0;
            kind         <= K_WRITE;
        end else begin
            miso      <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= abort;
            if (load_rx) begin
                cnt  <= CNT_W'(RX_W);
                kind <= kind_sel;
            end
            if (shift_rx)
                cnt <= cnt - 1'b1;
            if (complete_rx) begin
                rx_data  <= rx_shift(rx_sh, mosi);
                rx_valid <= 1'b1;
                if (kind == K_RDADDR)
                    addr_pending <= 1'b1;
            end
            // The first data bit is already driven in the cycle after the
            // load, so DATA_W-1 bits remain to be counted.
            if (load_tx) begin
                miso <= tx_bit(tx_data);
                cnt  <= CNT_W'(DATA_W - 1);
            end
            if (shift_tx) begin
                miso <= tx_bit(tx_sh);
                cnt  <= cnt - 1'b1;
            end
            if (finish_tx)
                addr_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_rx)
            rx_sh <= rx_shift(rx_sh, mosi);
        if (load_tx)
            tx_sh <= tx_shift(tx_data);
        else if (shift_tx)
            tx_sh <= tx_shift(tx_sh);
    end

endmodule

// File: tb/tb_spi_slave_framed.sv
// Testbench for spi_slave_framed. Two instances share every input: one is
// MSB-first and one is LSB-first. A transaction-level model predicts
// rx_data, the pending-address flag and the miso bit streams of both.
module tb_spi_slave_framed;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int RX_W   = ADDR_W + 2;

    logic clk = 1'b0;
    logic rst, ss_n, mosi, tx_valid;
    logic [DATA_W-1:0] tx_data;

    logic            miso_m, rx_valid_m, tx_ready_m, frame_err_m, busy_m;
    logic            miso_l, rx_valid_l, tx_ready_l, frame_err_l, busy_l;
    logic [RX_W-1:0] rx_data_m, rx_data_l;

    int n_checks = 0;
    int n_errors = 0;

    logic            pend;
    logic [RX_W-1:0] exp_m, exp_l;

    always #5 clk = ~clk;

    spi_slave_framed #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LSB_FIRST(0)) dut_m (
        .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .tx_data(tx_data),
        .tx_valid(tx_valid), .miso(miso_m), .rx_data(rx_data_m),
        .rx_valid(rx_valid_m), .tx_ready(tx_ready_m), .frame_err(frame_err_m),
        .busy(busy_m)
    );

    spi_slave_framed #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LSB_FIRST(1)) dut_l (
        .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .tx_data(tx_data),
        .tx_valid(tx_valid), .miso(miso_l), .rx_data(rx_data_l),
        .rx_valid(rx_valid_l), .tx_ready(tx_ready_l), .frame_err(frame_err_l),
        .busy(busy_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input string tag, input logic b, input logic v,
                        input logic fe, input logic tr);
        check_eq({tag, ".busy_m"},      busy_m,      b);
        check_eq({tag, ".busy_l"},      busy_l,      b);
        check_eq({tag, ".rx_valid_m"},  rx_valid_m,  v);
        check_eq({tag, ".rx_valid_l"},  rx_valid_l,  v);
        check_eq({tag, ".frame_err_m"}, frame_err_m, fe);
        check_eq({tag, ".frame_err_l"}, frame_err_l, fe);
        check_eq({tag, ".tx_ready_m"},  tx_ready_m,  tr);
        check_eq({tag, ".tx_ready_l"},  tx_ready_l,  tr);
    endtask

    task automatic data_chk(input string tag);
        check_eq({tag, ".rx_data_m"}, rx_data_m, exp_m);
        check_eq({tag, ".rx_data_l"}, rx_data_l, exp_l);
        check_eq({tag, ".pend_m"}, dut_m.addr_pending, pend);
        check_eq({tag, ".pend_l"}, dut_l.addr_pending, pend);
    endtask

    task automatic miso_chk(input string tag, input logic em, input logic el);
        check_eq({tag, ".miso_m"}, miso_m, em);
        check_eq({tag, ".miso_l"}, miso_l, el);
    endtask

    // Reverses a value into send order: with it, the MSB-first instance
    // assembles exactly v.
    function automatic logic [RX_W-1:0] msb_seq(input logic [RX_W-1:0] v);
        logic [RX_W-1:0] s;
        for (int i = 0; i < RX_W; i++) s[i] = v[RX_W-1-i];
        return s;
    endfunction

    // seq[i] is the i-th payload bit on the wire.
    // mode: 0 normal, 1 abort in CHK_CMD, 2 abort in RX at bit k,
    //       3 ss_n rises with the final bit, 4 abort in WAIT_TX after k waits,
    //       5 abort in SEND at step k, 6 reset in SEND at step k.
    task automatic frame(input logic sel, input logic [RX_W-1:0] seq,
                         input int mode, input int k, input logic [DATA_W-1:0] txd);
        int kind;
        int d;
        ss_n = 1'b0; mosi = 1'($urandom); tx_valid = 1'($urandom);
        tick();
        ctrl("chk", 1, 0, 0, 0);
        miso_chk("chk", 0, 0);
        if (mode == 1) begin
            ss_n = 1'b1; tick();
            ctrl("ab_chk", 0, 0, 1, 0); data_chk("ab_chk");
            tick(); ctrl("ab_chk2", 0, 0, 0, 0);
            return;
        end
        kind = sel ? (pend ? 2 : 1) : 0;
        mosi = sel; tick();
        ctrl("sel", 1, 0, 0, 0);
        for (int i = 0; i < RX_W; i++) begin
            mosi = seq[i]; tx_valid = 1'($urandom); tx_data = DATA_W'($urandom);
            ss_n = ((mode == 2 || mode == 3) && i == k) ? 1'b1 : 1'b0;
            tick();
            if (ss_n && i < RX_W - 1) begin
                ctrl("ab_rx", 0, 0, 1, 0); data_chk("ab_rx");
                tick(); ctrl("ab_rx2", 0, 0, 0, 0);
                return;
            end
            if (i < RX_W - 1) ctrl("rx", 1, 0, 0, 0);
        end
        exp_m = msb_seq(seq);
        exp_l = seq;
        if (kind == 1) pend = 1'b1;
        ctrl("rxdone", !ss_n, 1, 0, (kind == 2) && !ss_n);
        data_chk("rxdone");
        tx_valid = 1'b0;
        if (ss_n) begin
            tick(); ctrl("fin_ss", 0, 0, 0, 0);
            return;
        end
        if (kind != 2) begin
            mosi = 1'($urandom); tx_valid = 1'($urandom); tick();
            ctrl("done", 1, 0, 0, 0); miso_chk("done", 0, 0);
            ss_n = 1'b1; tx_valid = 1'b0; tick();
            ctrl("idle", 0, 0, 0, 0);
            return;
        end
        d = (mode == 4) ? k : int'($urandom_range(0, 2));
        for (int j = 0; j < d; j++) begin
            tick(); ctrl("wait", 1, 0, 0, 1); miso_chk("wait", 0, 0);
        end
        if (mode == 4) begin
            ss_n = 1'b1; tick();
            ctrl("ab_wait", 0, 0, 1, 0); data_chk("ab_wait");
            tick(); ctrl("ab_wait2", 0, 0, 0, 0);
            return;
        end
        tx_data = txd; tx_valid = 1'b1; tick();
        tx_valid = 1'b0; tx_data = DATA_W'($urandom);
        ctrl("load", 1, 0, 0, 0);
        miso_chk("tx0", txd[DATA_W-1], txd[0]);
        for (int b = 1; b <= DATA_W; b++) begin
            if (mode == 5 && b == k) ss_n = 1'b1;
            if (mode == 6 && b == k) begin rst = 1'b1; ss_n = 1'b1; end
            tick();
            rst = 1'b0;
            if (mode == 5 && b == k) begin
                ctrl("ab_send", 0, 0, 1, 0); miso_chk("ab_send", 0, 0);
                data_chk("ab_send");
                tick(); ctrl("ab_send2", 0, 0, 0, 0);
                return;
            end
            if (mode == 6 && b == k) begin
                pend = 1'b0; exp_m = '0; exp_l = '0;
                ctrl("rst_send", 0, 0, 0, 0); miso_chk("rst_send", 0, 0);
                data_chk("rst_send");
                tick(); ctrl("rst_send2", 0, 0, 0, 0);
                return;
            end
            if (b < DATA_W) begin
                ctrl("send", 1, 0, 0, 0);
                miso_chk("txb", txd[DATA_W-1-b], txd[b]);
            end
        end
        pend = 1'b0;
        ctrl("sent", 1, 0, 0, 0); miso_chk("tx_end", 0, 0); data_chk("sent");
        ss_n = 1'b1; tick();
        ctrl("idle", 0, 0, 0, 0);
    endtask

    initial begin
        int mode, k, gap;
        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        pend = 1'b0; exp_m = '0; exp_l = '0;
        tick(); tick();
        ctrl("reset", 0, 0, 0, 0); miso_chk("reset", 0, 0); data_chk("reset");
        rst = 1'b0; tick();
        ctrl("post_rst", 0, 0, 0, 0);

        // Write, MSB-first payload 0x0A5.
        frame(1'b0, msb_seq(10'h0A5), 0, 0, 8'h00);
        check_eq("t1.rx_data_m", rx_data_m, 10'h0A5);
        // Read address, then read data 0xC3.
        frame(1'b1, msb_seq(10'h233), 0, 0, 8'h00);
        check_eq("t2.rx_data_m", rx_data_m, 10'h233);
        frame(1'b1, msb_seq(10'h300), 0, 0, 8'hC3);
        // A read-data frame with no pending address becomes an address read.
        frame(1'b1, msb_seq(10'h301), 0, 0, 8'h00);
        check_eq("t3.pend", dut_m.addr_pending, 1'b1);
        // Abort after four payload bits.
        frame(1'b0, 10'h3FF, 2, 4, 8'h00);
        check_eq("t4.rx_data_m", rx_data_m, 10'h301);
        // Reset while bit 3 of 0xC3 is on miso.
        frame(1'b1, 10'h155, 6, 4, 8'hC3);
        // LSB-first payload 0x0A5 and read data 0x01.
        frame(1'b0, 10'h0A5, 0, 0, 8'h00);
        check_eq("t6.rx_data_l", rx_data_l, 10'h0A5);
        frame(1'b1, 10'h001, 0, 0, 8'h00);
        frame(1'b1, 10'h003, 0, 0, 8'h01);
        // Remaining abort and edge cases.
        frame(1'b0, 10'h2AA, 1, 0, 8'h00);
        frame(1'b1, 10'h1C7, 3, RX_W - 1, 8'h00);
        frame(1'b1, 10'h0F0, 4, 1, 8'h00);
        frame(1'b1, 10'h0F1, 5, 5, 8'h5A);
        frame(1'b1, 10'h0F2, 0, 0, 8'hA7);

        for (int n = 0; n < 80; n++) begin
            mode = int'($urandom_range(0, 6));
            case (mode)
                2:       k = int'($urandom_range(0, RX_W - 2));
                3:       k = RX_W - 1;
                4:       k = int'($urandom_range(0, 3));
                5, 6:    k = int'($urandom_range(1, DATA_W));
                default: k = 0;
            endcase
            frame(1'($urandom), RX_W'($urandom), mode, k, DATA_W'($urandom));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                ss_n = 1'b1; mosi = 1'($urandom); tx_valid = 1'($urandom);
                tick();
                ctrl("gap", 0, 0, 0, 0);
            end
            tx_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_framed.md
Name: spi_slave_framed

Overview:
Parametrised SPI slave front-end for the SPI/RAM subsystem. It deserialises command/address/data frames from an SPI master (mode 0, one bit per clk while ss_n is low) and presents them as parallel words. It serialises read data supplied by the memory side. Compared with the previous slave it adds configurable widths and bit order, a one-cycle rx_valid strobe, a tx_ready handshake, and abort/frame-error detection.

Parameters:
ADDR_W, 8, payload width of address/data field
DATA_W, 8, width of read data returned on miso
LSB_FIRST, 0, 0 = MSB-first on mosi and miso, 1 = LSB-first
RX_W, ADDR_W+2 (derived localparam), 2 command bits plus payload

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
ss_n  in  1  slave select, active-low
mosi  in  1  serial data from master
tx_data  in  DATA_W  read data from memory side
tx_valid  in  1  tx_data valid, sampled only when tx_ready=1
miso  out  1  serial data to master (registered)
rx_data  out  RX_W  last completed frame; [RX_W-1:RX_W-2] = command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data)
rx_valid  out  1  one-cycle strobe when rx_data updates
tx_ready  out  1  high while waiting for read data
frame_err  out  1  one-cycle strobe on aborted frame
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at posedge, any state): state=IDLE; miso, rx_valid, tx_ready, frame_err=0; rx_data=0; addr_pending=0; counters=0. Reset mid-frame aborts silently with no frame_err.
- States: IDLE, CHK_CMD, RX, WAIT_TX, SEND, DONE. Counter width is $clog2(max(RX_W,DATA_W)+1).
- IDLE: ss_n=0 -> CHK_CMD.
- CHK_CMD: sample mosi as the rd/wr select bit, load bit counter=RX_W, go to RX. Record kind: mosi=0 -> WRITE. mosi=1 and addr_pending=1 -> RDDATA. mosi=1 and addr_pending=0 -> RDADDR.
- RX: shift mosi into an internal shift register, one bit per cycle, for RX_W cycles. The first bit lands at the MSB, or at the LSB when LSB_FIRST=1. rx_data is not touched during shifting.
- RX completion: in the cycle after the last bit, copy the shift register to rx_data and pulse rx_valid=1 for exactly one cycle.
  - RDADDR: set addr_pending=1 in the same cycle, then go to DONE.
  - WRITE: go to DONE.
  - RDDATA: go to WAIT_TX.
- Latency: ss_n low in cycle 0 -> rx_valid in cycle RX_W+2.
- WAIT_TX: tx_ready=1. On tx_valid=1, load tx_data into the tx shift register, drop tx_ready, go to SEND. tx_valid in any other state is ignored.
- SEND: drive miso with one bit per cycle for DATA_W cycles, starting the cycle after the load. Order is bit DATA_W-1 down to 0, or 0 up when LSB_FIRST=1. After the last bit, clear addr_pending and go to DONE.
- miso=0 in every state except SEND.
- DONE: ignore mosi; ss_n=1 -> IDLE.
- ss_n=1 in CHK_CMD, RX, WAIT_TX or SEND -> IDLE next cycle, frame_err=1 for one cycle, no rx_valid, rx_data unchanged, addr_pending unchanged (a retry of an aborted read is allowed).
- ss_n=1 in DONE or IDLE never raises frame_err.
- ss_n=1 in the same cycle as the final RX bit: the bit is captured, the frame completes normally, then the block returns to IDLE.

Test Plan:
1. Write (defaults): ss_n low, mosi 0 then 10'b00_1010_0101 -> rx_data=10'h0A5, rx_valid high exactly one cycle at cycle 12, frame_err=0, tx_ready never high.
2. Read-addr then read-data: frame 1, 10'b10_0011_0011 -> rx_data=10'h233, addr_pending=1. Next frame 1, 10'b11_0000_0000 -> rx_valid, tx_ready=1. tx_valid with tx_data=8'hC3 -> miso 1,1,0,0,0,0,1,1 on the following 8 cycles, then addr_pending=0.
3. Read-data with no pending address: frame 1, 10'b11_0000_0001 -> treated as RDADDR, rx_valid, addr_pending=1, tx_ready stays 0.
4. Abort: ss_n raised after 4 RX bits -> frame_err one cycle, rx_data keeps its prior value, rx_valid=0, busy=0 the next cycle.
5. rst=1 during SEND of 8'hC3 (bit 3) -> next cycle miso=0, state IDLE, addr_pending=0, no frame_err.
6. LSB_FIRST=1, tx_data=8'h01 -> miso 1,0,0,0,0,0,0,0. Write payload bits sent 1,0,1,0,0,1,0,1,0,0 -> rx_data=10'h0A5.
